// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter.
// One add-3 correction pass plus one shift per clock; optional two's-complement
// input converted as sign plus magnitude. Valid/ready handshake on both sides.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  out_ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   bcd_adj;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   res_bcd_q, res_bcd_d;
    logic            res_neg_q, res_neg_d;
    logic            res_ovf_q, res_ovf_d;

    logic            in_neg;
    logic [WIDTH-1:0] in_mag;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: working shift/BCD registers and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            res_bcd_q <= '0;
            res_neg_q <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            res_bcd_q <= res_bcd_d;
            res_neg_q <= res_neg_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign/magnitude split of the incoming value
    always_comb begin
        in_neg = (SIGNED != 0) && in_data[WIDTH-1];
        in_mag = in_neg ? ('0 - in_data) : in_data;
    end

    // Add-3 correction on every BCD digit that is 5 or more, all digits at once
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath next values: load on accept, shift while counting, then a
    // final cycle (counter at zero) copies the working registers into the
    // result registers so the outputs stay untouched during a conversion.
    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        res_bcd_d = res_bcd_q;
        res_neg_d = res_neg_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d = in_mag;
                    neg_d = in_neg;
                    bcd_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = CW'(WIDTH);
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    // bit leaving the top digit is a carry into digit DIGITS
                    ovf_d = ovf_q | bcd_adj[BW-1];
                    bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
                    bin_d = {bin_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_bcd_d = bcd_q;
                    res_neg_d = neg_q;
                    res_ovf_d = ovf_q;
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_bcd   = res_bcd_q;
        out_neg   = res_neg_q;
        out_ovf   = res_ovf_q;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of bin_to_bcd_seq in several
// configurations, plus a short randomised run against a decimal model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [5:0]  iv, ordy;
    logic [5:0]  ir, ov, on, oo;
    logic [11:0] bcd_a, bcd_b;
    logic [7:0]  bcd_c;
    logic [19:0] bcd_d;
    logic [15:0] bcd_e, bcd_f;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_a (
        .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_bcd(bcd_a), .out_neg(on[0]), .out_ovf(oo[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_b (
        .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_bcd(bcd_b), .out_neg(on[1]), .out_ovf(oo[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_c (
        .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_bcd(bcd_c), .out_neg(on[2]), .out_ovf(oo[2]), .out_valid(ov[2]), .out_ready(ordy[2]));
    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_d (
        .clk(clk), .rst(rst), .in_data(din[15:0]), .in_valid(iv[3]), .in_ready(ir[3]),
        .out_bcd(bcd_d), .out_neg(on[3]), .out_ovf(oo[3]), .out_valid(ov[3]), .out_ready(ordy[3]));
    bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4), .SIGNED(0)) u_e (
        .clk(clk), .rst(rst), .in_data(din[11:0]), .in_valid(iv[4]), .in_ready(ir[4]),
        .out_bcd(bcd_e), .out_neg(on[4]), .out_ovf(oo[4]), .out_valid(ov[4]), .out_ready(ordy[4]));
    bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4), .SIGNED(1)) u_f (
        .clk(clk), .rst(rst), .in_data(din[11:0]), .in_valid(iv[5]), .in_ready(ir[5]),
        .out_bcd(bcd_f), .out_neg(on[5]), .out_ovf(oo[5]), .out_valid(ov[5]), .out_ready(ordy[5]));

    function automatic logic [39:0] bcd_of(int k);
        case (k)
            0:       return {28'd0, bcd_a};
            1:       return {28'd0, bcd_b};
            2:       return {32'd0, bcd_c};
            3:       return {20'd0, bcd_d};
            4:       return {24'd0, bcd_e};
            default: return {24'd0, bcd_f};
        endcase
    endfunction

    // Decimal model: low d digits of m, packed BCD
    function automatic logic [39:0] dec(int unsigned m, int d);
        logic [39:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic check(string tag, logic [39:0] obs, logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents v for exactly one edge
    task automatic send(int k, logic [31:0] v);
        int t = 0;
        while (!ir[k] && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_wait", {39'd0, ir[k]}, 40'd1);
        din   = v;
        iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        din   = $urandom;
    endtask

    // One full transaction with latency, result, backpressure and drain checks
    task automatic run(int k, int w, logic [31:0] v, logic [39:0] eb, logic en, logic eo,
                       int hold, string tag);
        int lat;
        bit stable;
        send(k, v);
        // out_ready pulse during the conversion has no effect
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        lat = 1;
        while (!ov[k] && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, 40'(lat), 40'(w + 1));
        check({tag, "_bcd"}, bcd_of(k), eb);
        check({tag, "_neg"}, {39'd0, on[k]}, {39'd0, en});
        check({tag, "_ovf"}, {39'd0, oo[k]}, {39'd0, eo});
        // in_valid while busy is ignored; outputs must hold still
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            iv[k] = 1'b1;
            din   = $urandom;
            @(posedge clk); #1;
            if (bcd_of(k) !== eb || ov[k] !== 1'b1 || ir[k] !== 1'b0) stable = 1'b0;
        end
        iv[k] = 1'b0;
        if (hold > 0) check({tag, "_hold"}, {39'd0, stable}, 40'd1);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        check({tag, "_drop"}, {38'd0, ov[k], ir[k]}, 40'd1);
        @(posedge clk); #1;
        check({tag, "_noqueue"}, {38'd0, ov[k], ir[k]}, 40'd1);
    endtask

    initial begin
        bit          seen;
        logic [11:0] rv;
        int unsigned mag;
        logic        neg;

        rst  = 1'b1;
        iv   = '0;
        ordy = '0;
        din  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", {26'd0, ov[0], ir[0], bcd_a}, {26'd0, 1'b0, 1'b1, 12'h000});
        check("rst_b", {38'd0, on[1], oo[1]}, 40'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned 8-bit, 3 digits
        run(0, 8, 32'd255, 40'h255, 1'b0, 1'b0, 0, "a255");
        run(0, 8, 32'd0,   40'h000, 1'b0, 1'b0, 0, "a0");
        run(0, 8, 32'd100, 40'h100, 1'b0, 1'b0, 20, "a100_bp");

        // Signed 8-bit, 3 digits
        run(1, 8, 32'h80, 40'h128, 1'b1, 1'b0, 0, "b80");
        run(1, 8, 32'hFF, 40'h001, 1'b1, 1'b0, 0, "bFF");
        run(1, 8, 32'h7F, 40'h127, 1'b0, 1'b0, 0, "b7F");
        run(1, 8, 32'h00, 40'h000, 1'b0, 1'b0, 0, "b00");

        // Unsigned 8-bit, 2 digits: truncation
        run(2, 8, 32'd255, 40'h55, 1'b0, 1'b1, 0, "c255");
        run(2, 8, 32'd99,  40'h99, 1'b0, 1'b0, 0, "c99");
        run(2, 8, 32'd100, 40'h00, 1'b0, 1'b1, 0, "c100");

        // Unsigned 16-bit, 5 digits, with reset mid-conversion
        run(3, 16, 32'd65535, 40'h65535, 1'b0, 1'b0, 0, "d65535");
        send(3, 32'd12345);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("d_rst_bcd", bcd_of(3), 40'd0);
        check("d_rst_hs", {38'd0, ov[3], ir[3]}, 40'd1);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ov[3]) seen = 1'b1;
        end
        check("d_rst_nopulse", {39'd0, seen}, 40'd0);
        run(3, 16, 32'd12345, 40'h12345, 1'b0, 1'b0, 0, "d12345");

        // Randomised 12-bit, 4 digits, unsigned and signed
        for (int n = 0; n < 8; n++) begin
            for (int k = 4; k <= 5; k++) begin
                rv  = 12'($urandom);
                neg = (k == 5) && rv[11];
                mag = neg ? (32'd4096 - 32'(rv)) : 32'(rv);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                run(k, 12, 32'(rv), dec(mag, 4), neg, 1'b0, int'($urandom_range(0, 3)),
                    (k == 5) ? "rnd_s" : "rnd_u");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
